aes_req_arbiter: RTL

- Shares the single fixed-key AES-128 encryption pipeline between two independent requesters. The pipeline has fixed latency, no backpressure, and one block per cycle.
- Arbitrates round-robin and drives the core input.
- Carries a requester tag through a shadow pipeline aligned with the core latency, then steers each ciphertext back to the requester that issued it.
- Enforces a per-requester outstanding-request limit and flags tag/valid misalignment.

---
 rtl/aes_req_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: shares one fixed-latency AES-128 encryption pipeline between
// two requesters. Arbitration is round-robin, and each requester has a limit on
// blocks in flight. A {valid, id} tag travels through a shadow pipeline that is
// aligned with the core, so each ciphertext is returned to the requester that
// issued it.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   reqN_valid/data   plaintext offer from requester N (N = 0, 1)
//   reqN_ready        combinational grant; a block is accepted when valid & ready
//   core_din/_valid   registered plaintext into the AES core
//   core_dout/_valid  ciphertext returned by the AES core, LATENCY cycles later
//   rspN_valid/data   one-cycle ciphertext strobe to requester N; data holds
//   align_err         sticky flag: the core output and the tag pipeline disagreed
//   busy              some block is still in flight for either requester
module aes_req_arbiter #(
    parameter int unsigned LATENCY = 9,   // core valid shift depth, >= 2
    parameter int unsigned MAX_OUT = 4,   // per-requester in-flight limit, 1..15
    localparam int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [DATA_W-1:0] core_din,
    output logic              core_din_valid,
    input  logic [DATA_W-1:0] core_dout,
    input  logic              core_dout_valid,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              align_err,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    logic                      elig0;
    logic                      elig1;
    logic                      grant0;
    logic                      grant1;
    logic                      last_grant;
    logic [CNT_W-1:0]          cnt0;
    logic [CNT_W-1:0]          cnt1;
    logic [CNT_W-1:0]          cnt0_nxt;
    logic [CNT_W-1:0]          cnt1_nxt;
    tag_t                      tag_s0;
    tag_t [LATENCY-1:0]        tag_pipe;
    tag_t                      tag_last;
    logic                      ret0;
    logic                      ret1;

    // Round-robin grant. When both requesters are eligible, the one that did
    // not win last time wins now.
    always_comb begin
        elig0  = req0_valid && (cnt0 < CNT_MAX);
        elig1  = req1_valid && (cnt1 < CNT_MAX);
        grant0 = elig0 && (!elig1 || last_grant);
        grant1 = elig1 && (!elig0 || !last_grant);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // The tag leaving the shadow pipeline lines up with core_dout_valid.
    assign tag_last = tag_pipe[LATENCY-1];

    // A credit is returned whenever a valid tag leaves the pipeline, including
    // when the core dropped the block, so credits are never leaked.
    always_comb begin
        ret0 = tag_last.valid && !tag_last.id;
        ret1 = tag_last.valid &&  tag_last.id;
    end

    // Next outstanding counts. Accept and return in the same cycle cancel out.
    always_comb begin
        cnt0_nxt = cnt0;
        cnt1_nxt = cnt1;
        unique case ({grant0, ret0})
            2'b10:   cnt0_nxt = cnt0 + CNT_ONE;
            2'b01:   cnt0_nxt = (cnt0 != '0) ? cnt0 - CNT_ONE : cnt0;
            default: cnt0_nxt = cnt0;
        endcase
        unique case ({grant1, ret1})
            2'b10:   cnt1_nxt = cnt1 + CNT_ONE;
            2'b01:   cnt1_nxt = (cnt1 != '0) ? cnt1 - CNT_ONE : cnt1;
            default: cnt1_nxt = cnt1;
        endcase
    end

    // Core input register and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_din       <= '0;
            core_din_valid <= 1'b0;
            last_grant     <= 1'b1;
        end else begin
            core_din_valid <= grant0 || grant1;
            if (grant0) begin
                core_din   <= req0_data;
                last_grant <= 1'b0;
            end else if (grant1) begin
                core_din   <= req1_data;
                last_grant <= 1'b1;
            end
        end
    end

    // Shadow tag pipeline. tag_s0 sits alongside core_din_valid, and the
    // following LATENCY stages match the core's internal valid shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_s0   <= '0;
            tag_pipe <= '0;
        end else begin
            tag_s0.valid <= grant0 || grant1;
            tag_s0.id    <= grant1;
            tag_pipe     <= {tag_pipe[LATENCY-2:0], tag_s0};
        end
    end

    // Steer the ciphertext back to the requester named by the tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= core_dout_valid && ret0;
            rsp1_valid <= core_dout_valid && ret1;
            if (core_dout_valid && ret0) begin
                rsp0_data <= core_dout;
            end
            if (core_dout_valid && ret1) begin
                rsp1_data <= core_dout;
            end
        end
    end

    // Sticky misalignment flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_err <= 1'b0;
        end else if (core_dout_valid != tag_last.valid) begin
            align_err <= 1'b1;
        end
    end

    // Outstanding counters. busy is registered from the next counts so that it
    // tracks the counters in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
            busy <= 1'b0;
        end else begin
            cnt0 <= cnt0_nxt;
            cnt1 <= cnt1_nxt;
            busy <= (cnt0_nxt != '0) || (cnt1_nxt != '0);
        end
    end

endmodule
